// File: rtl/ann_ff_engine_if.sv
// rtl/ann_ff_engine_if.sv - weight-write, input-vector and result handshake bundle for ann_ff_engine
interface ann_ff_engine_if #(
  parameter int DW    = 8,
  parameter int N_IN  = 2,
  parameter int N_HID = 2
);
  localparam int NW = N_HID*(N_IN+1) + N_HID + 1;
  localparam int AW = $clog2(NW);

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*DW-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic                 out_class;
  logic                 busy;

  modport master (
    output wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_class, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_class, busy
  );
endinterface

// File: rtl/ann_ff_engine.sv
// rtl/ann_ff_engine.sv - serial fixed-point MLP (N_IN -> N_HID ReLU -> 1) with one MAC per cycle
module ann_ff_engine #(
  parameter int DW    = 8,
  parameter int FRAC  = 4,
  parameter int N_IN  = 2,
  parameter int N_HID = 2,
  parameter int ACC_W = 2*DW + 8
) (
  input  logic             clk,
  input  logic             rst,
  ann_ff_engine_if.slave   bus
);
  localparam int NW   = N_HID*(N_IN+1) + N_HID + 1;
  localparam int AW   = $clog2(NW);
  localparam int OW   = N_HID*(N_IN+1);
  localparam int TMAX = ((N_IN > N_HID) ? N_IN : N_HID) + 1;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DW-1)));

  typedef enum logic [1:0] {IDLE, MAC_H, MAC_O, DONE} state_t;

  state_t state, state_nx;

  logic signed [DW-1:0]    w_mem [NW];
  logic signed [DW-1:0]    x_reg [N_IN];
  logic signed [DW-1:0]    h_reg [N_HID];
  logic [CW-1:0]           h_idx;
  logic [CW-1:0]           t_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    out_q;
  logic                    class_q;

  logic signed [DW-1:0]    opd;
  logic signed [DW-1:0]    wsel;
  logic                    is_bias;
  int                      widx;
  logic signed [2*DW-1:0]  mul_a;
  logic signed [2*DW-1:0]  mul_b;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [DW-1:0]    sat_val;
  logic signed [DW-1:0]    relu_val;
  logic                    wr_ok;

  // Writes only land while idle and not in reset; out-of-range indices are dropped.
  assign wr_ok = bus.wr_en && !rst && (state == IDLE) &&
                 ({1'b0, bus.wr_addr} < (AW+1)'(NW));

  // Select the operand and weight for the current term; the last term of each neuron is its bias.
  always_comb begin
    opd     = '0;
    wsel    = '0;
    is_bias = 1'b0;
    widx    = 0;
    if (state == MAC_O) begin
      widx    = OW + int'(t_idx);
      is_bias = (int'(t_idx) == N_HID);
      for (int j = 0; j < N_HID; j++) begin
        if (int'(t_idx) == j) opd = h_reg[j];
      end
    end else begin
      widx    = int'(h_idx)*(N_IN+1) + int'(t_idx);
      is_bias = (int'(t_idx) == N_IN);
      for (int i = 0; i < N_IN; i++) begin
        if (int'(t_idx) == i) opd = x_reg[i];
      end
    end
    for (int k = 0; k < NW; k++) begin
      if (k == widx) wsel = w_mem[k];
    end
  end

  // One multiply-accumulate step, then rescale, saturate and rectify the candidate neuron value.
  always_comb begin
    mul_a = (2*DW)'(opd);
    mul_b = (2*DW)'(wsel);
    prod  = mul_a * mul_b;
    if (is_bias) term = ACC_W'(wsel) <<< FRAC;
    else         term = ACC_W'(prod);
    sum     = acc + term;
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
    else                        sat_val = shifted[DW-1:0];
    relu_val = sat_val[DW-1] ? '0 : sat_val;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.out_data  = out_q;
    bus.out_class = class_q;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = MAC_H;
      MAC_H:   if (is_bias && (int'(h_idx) == N_HID-1)) state_nx = MAC_O;
      MAC_O:   if (is_bias) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Weight memory survives reset so a network only needs loading once.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < NW; k++) begin
        if (int'(bus.wr_addr) == k) w_mem[k] <= bus.wr_data;
      end
    end
  end

  // Datapath: input capture, per-term accumulation, neuron write-back and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_idx   <= '0;
      t_idx   <= '0;
      acc     <= '0;
      out_q   <= '0;
      class_q <= 1'b0;
      for (int j = 0; j < N_HID; j++) h_reg[j] <= '0;
      for (int i = 0; i < N_IN; i++)  x_reg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= bus.in_data[i*DW +: DW];
            h_idx <= '0;
            t_idx <= '0;
            acc   <= '0;
          end
        end
        MAC_H: begin
          if (is_bias) begin
            for (int j = 0; j < N_HID; j++) begin
              if (int'(h_idx) == j) h_reg[j] <= relu_val;
            end
            acc   <= '0;
            t_idx <= '0;
            h_idx <= (int'(h_idx) == N_HID-1) ? '0 : h_idx + CW'(1);
          end else begin
            acc   <= sum;
            t_idx <= t_idx + CW'(1);
          end
        end
        MAC_O: begin
          if (is_bias) begin
            out_q   <= sat_val;
            class_q <= !sat_val[DW-1] && (sat_val != '0);
            acc     <= '0;
            t_idx   <= '0;
          end else begin
            acc   <= sum;
            t_idx <= t_idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
